// File: rtl/polyvec_basemul_acc_seq.sv
// Sequencer for the polyvec pointwise multiply-accumulate: walks KYBER_K operand
// loads / basemul runs / accumulate sweeps over RAM C, with an optional Barrett pass.
module polyvec_basemul_acc_seq #(
  parameter int KYBER_K = 3,
  parameter int NPAIRS  = 128,
  parameter int AW      = 7,
  parameter int RD_LAT  = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          redc_en,
  input  logic          clr,
  input  logic          load_done,
  input  logic          bm_done,
  output logic          load_req,
  output logic [1:0]    poly_idx,
  output logic [AW-1:0] addr,
  output logic          ram_ab_re,
  output logic          bm_load,
  output logic          bm_start,
  output logic          bm_rd,
  output logic          ram_c_re,
  output logic          ram_c_we,
  output logic [AW-1:0] c_waddr,
  output logic          acc_first,
  output logic          barr_redc,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(NPAIRS + RD_LAT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(NPAIRS + RD_LAT - 1);
  localparam logic [CW-1:0] ISS_LAST  = CW'(NPAIRS - 1);
  localparam logic [1:0]    POLY_LAST = 2'(KYBER_K - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LOAD, S_FETCH, S_KICK, S_WAIT_BM, S_ACC, S_REDC, S_FIN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          redc_lat;
  logic          bm_prev;
  logic          sweep, sweep_end, bm_edge;
  logic          wr_iss, af_iss, br_iss;

  logic [RD_LAT:1]         ld_pipe, we_pipe, af_pipe, br_pipe;
  logic [RD_LAT:1][AW-1:0] wa_pipe;

  assign sweep     = (state == S_FETCH) || (state == S_ACC) || (state == S_REDC);
  assign sweep_end = sweep && (cnt == CNT_LAST);
  assign bm_edge   = bm_done && !bm_prev;

  // A read issued this cycle becomes a RAM C write RD_LAT cycles later.
  assign wr_iss = bm_rd || (ram_c_re && (state == S_REDC));
  assign af_iss = bm_rd && (poly_idx == 2'd0);
  assign br_iss = ram_c_re && (state == S_REDC);

  assign bm_load   = ld_pipe[RD_LAT];
  assign ram_c_we  = we_pipe[RD_LAT];
  assign acc_first = af_pipe[RD_LAT];
  assign barr_redc = br_pipe[RD_LAT];
  assign c_waddr   = wa_pipe[RD_LAT];

  // Edge register keeps tracking bm_done in every state, clr included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bm_prev <= 1'b0;
    else          bm_prev <= bm_done;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_pipe <= '0;
      we_pipe <= '0;
      af_pipe <= '0;
      br_pipe <= '0;
      wa_pipe <= '0;
    end else if (clr) begin
      ld_pipe <= '0;
      we_pipe <= '0;
      af_pipe <= '0;
      br_pipe <= '0;
      wa_pipe <= '0;
    end else begin
      ld_pipe[1] <= ram_ab_re;
      we_pipe[1] <= wr_iss;
      af_pipe[1] <= af_iss;
      br_pipe[1] <= br_iss;
      wa_pipe[1] <= addr;
      for (int k = 2; k <= RD_LAT; k++) begin
        ld_pipe[k] <= ld_pipe[k-1];
        we_pipe[k] <= we_pipe[k-1];
        af_pipe[k] <= af_pipe[k-1];
        br_pipe[k] <= br_pipe[k-1];
        wa_pipe[k] <= wa_pipe[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr      <= '0;
      poly_idx  <= '0;
      redc_lat  <= 1'b0;
      load_req  <= 1'b0;
      ram_ab_re <= 1'b0;
      bm_start  <= 1'b0;
      bm_rd     <= 1'b0;
      ram_c_re  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (clr) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr      <= '0;
      poly_idx  <= '0;
      redc_lat  <= 1'b0;
      load_req  <= 1'b0;
      ram_ab_re <= 1'b0;
      bm_start  <= 1'b0;
      bm_rd     <= 1'b0;
      ram_c_re  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      bm_start <= 1'b0;
      done     <= 1'b0;
      // Shared sweep stepping: address stops at NPAIRS-1 and holds through the drain.
      if (sweep && !sweep_end) begin
        cnt <= cnt + 1'b1;
        if (cnt < ISS_LAST) addr <= addr + 1'b1;
        else begin
          ram_ab_re <= 1'b0;
          bm_rd     <= 1'b0;
          ram_c_re  <= 1'b0;
        end
      end
      case (state)
        S_IDLE: if (start) begin
          state    <= S_WAIT_LOAD;
          busy     <= 1'b1;
          poly_idx <= '0;
          redc_lat <= redc_en;
          load_req <= 1'b1;
        end
        S_WAIT_LOAD: if (load_done) begin
          state     <= S_FETCH;
          load_req  <= 1'b0;
          ram_ab_re <= 1'b1;
          addr      <= '0;
          cnt       <= '0;
        end
        S_FETCH: if (sweep_end) begin
          state    <= S_KICK;
          bm_start <= 1'b1;
        end
        S_KICK: state <= S_WAIT_BM;
        S_WAIT_BM: if (bm_edge) begin
          state    <= S_ACC;
          bm_rd    <= 1'b1;
          ram_c_re <= (poly_idx != 2'd0);
          addr     <= '0;
          cnt      <= '0;
        end
        S_ACC: if (sweep_end) begin
          if (poly_idx == POLY_LAST) begin
            if (redc_lat) begin
              state    <= S_REDC;
              ram_c_re <= 1'b1;
              addr     <= '0;
              cnt      <= '0;
            end else begin
              state <= S_FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            state    <= S_WAIT_LOAD;
            poly_idx <= poly_idx + 1'b1;
            load_req <= 1'b1;
          end
        end
        S_REDC: if (sweep_end) begin
          state <= S_FIN;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_polyvec_basemul_acc_seq.sv
// Bench for polyvec_basemul_acc_seq: two configurations driven by an auto-responding
// loader/core model, with every run compared to an expected read/write schedule.
module tb_polyvec_basemul_acc_seq;
  localparam int NI = 2;

  bit   clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       st[NI], rdc[NI], clr[NI], ld[NI], bmd[NI];
  logic       load_req[NI], ram_ab_re[NI], bm_load[NI], bm_start[NI], bm_rd[NI];
  logic       ram_c_re[NI], ram_c_we[NI], acc_first[NI], barr_redc[NI], busy[NI], done[NI];
  logic [1:0] poly_idx[NI];
  logic [6:0] addr[NI], c_waddr[NI];

  polyvec_basemul_acc_seq #(.KYBER_K(2), .NPAIRS(4), .AW(7), .RD_LAT(1)) dut0 (
    .clk(clk), .reset_n(rst_n), .start(st[0]), .redc_en(rdc[0]), .clr(clr[0]),
    .load_done(ld[0]), .bm_done(bmd[0]), .load_req(load_req[0]), .poly_idx(poly_idx[0]),
    .addr(addr[0]), .ram_ab_re(ram_ab_re[0]), .bm_load(bm_load[0]), .bm_start(bm_start[0]),
    .bm_rd(bm_rd[0]), .ram_c_re(ram_c_re[0]), .ram_c_we(ram_c_we[0]), .c_waddr(c_waddr[0]),
    .acc_first(acc_first[0]), .barr_redc(barr_redc[0]), .busy(busy[0]), .done(done[0]));

  polyvec_basemul_acc_seq #(.KYBER_K(4), .NPAIRS(128), .AW(7), .RD_LAT(2)) dut1 (
    .clk(clk), .reset_n(rst_n), .start(st[1]), .redc_en(rdc[1]), .clr(clr[1]),
    .load_done(ld[1]), .bm_done(bmd[1]), .load_req(load_req[1]), .poly_idx(poly_idx[1]),
    .addr(addr[1]), .ram_ab_re(ram_ab_re[1]), .bm_load(bm_load[1]), .bm_start(bm_start[1]),
    .bm_rd(bm_rd[1]), .ram_c_re(ram_c_re[1]), .ram_c_we(ram_c_we[1]), .c_waddr(c_waddr[1]),
    .acc_first(acc_first[1]), .barr_redc(barr_redc[1]), .busy(busy[1]), .done(done[1]));

  function automatic int kk(input int i); return (i == 0) ? 2 : 4;   endfunction
  function automatic int nn(input int i); return (i == 0) ? 4 : 128; endfunction
  function automatic int ll(input int i); return (i == 0) ? 1 : 2;   endfunction
  function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction

  function automatic logic [31:0] outs(input int i);
    return {5'd0, load_req[i], poly_idx[i], addr[i], ram_ab_re[i], bm_load[i], bm_start[i],
            bm_rd[i], ram_c_re[i], ram_c_we[i], c_waddr[i], acc_first[i], barr_redc[i],
            busy[i], done[i]};
  endfunction

  // Control shared with the responder/monitor (written only by the main sequence).
  int sel = 0, ld_dly = 2, bm_dly = 5;
  bit auto_bm = 1'b1, man_bmd = 1'b0, mon_clr = 1'b0;

  // Loader and basemul-core stand-ins for the selected instance.
  initial begin
    int  lw, bw;
    bit  arm, lv, blv;
    lw = 0; bw = 0; arm = 0; lv = 0; blv = 0;
    for (int i = 0; i < NI; i++) begin ld[i] = 1'b0; bmd[i] = 1'b0; end
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        lw = 0; bw = 0; arm = 0; lv = 0; blv = 0;
      end else begin
        if (load_req[sel]) begin lv = (lw == ld_dly); lw++; end
        else begin lv = 0; lw = 0; end
        if (bm_start[sel]) begin blv = 0; bw = 0; arm = 1; end
        else if (arm) begin
          bw++;
          if (bw >= bm_dly) begin blv = 1; arm = 0; end
        end
      end
      for (int i = 0; i < NI; i++) begin
        ld[i]  = (i == sel) && lv;
        bmd[i] = (i == sel) ? (auto_bm ? blv : man_bmd) : 1'b0;
      end
    end
  end

  // Observation log of the selected instance.
  int cyc = 0;
  int n_done, n_lrise, n_bms, n_rd_cre, n_rd_only, n_cre_only, busy_at_done;
  bit lr_prev;
  int pq[$], abq[$], aba[$], blq[$], rdq[$], rda[$], wrcq[$], wra[$], wrf[$], wrb[$];

  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      n_done = 0; n_lrise = 0; n_bms = 0; n_rd_cre = 0; n_rd_only = 0; n_cre_only = 0;
      busy_at_done = -1; lr_prev = 0;
      pq.delete(); abq.delete(); aba.delete(); blq.delete(); rdq.delete(); rda.delete();
      wrcq.delete(); wra.delete(); wrf.delete(); wrb.delete();
    end else begin
      if (load_req[sel] && !lr_prev) begin n_lrise++; pq.push_back(int'(poly_idx[sel])); end
      lr_prev = load_req[sel];
      if (bm_start[sel]) n_bms++;
      if (done[sel]) begin n_done++; busy_at_done = int'(busy[sel]); end
      if (ram_ab_re[sel]) begin abq.push_back(cyc); aba.push_back(int'(addr[sel])); end
      if (bm_load[sel]) blq.push_back(cyc);
      if (bm_rd[sel] || ram_c_re[sel]) begin rdq.push_back(cyc); rda.push_back(int'(addr[sel])); end
      if (bm_rd[sel] && ram_c_re[sel])  n_rd_cre++;
      if (bm_rd[sel] && !ram_c_re[sel]) n_rd_only++;
      if (!bm_rd[sel] && ram_c_re[sel]) n_cre_only++;
      if (ram_c_we[sel]) begin
        wrcq.push_back(cyc); wra.push_back(int'(c_waddr[sel]));
        wrf.push_back(int'(acc_first[sel])); wrb.push_back(int'(barr_redc[sel]));
      end
    end
  end

  int checks = 0, failures = 0;
  bit last_ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) last_ok = 1'b1;
    else begin
      last_ok = 1'b0;
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic run_begin(input int i, input bit redc, input int ldd, input int bmdl);
    sel = i; ld_dly = ldd; bm_dly = bmdl;
    mon_clr = 1'b1; tick(1); mon_clr = 1'b0;
    rdc[i] = redc; st[i] = 1'b1;
    tick(1);
    st[i] = 1'b0; rdc[i] = ~redc;  // mode must have been latched at start
    chk("busy_after_start", busy[i], 1);
  endtask

  task automatic run_wait(input int budget);
    int t;
    t = 0;
    while (n_done == 0 && t < budget) begin tick(1); t++; end
    chk("run_finished", n_done != 0, 1);
    tick(4);
  endtask

  // Expected schedule: K accumulate sweeps (first one writes directly), then an
  // optional reduction sweep; every write trails its read by RD_LAT cycles.
  task automatic run_check(input int i, input bit redc);
    int k_, n_, l_, m;
    int ea[$], ef[$], eb[$];
    k_ = kk(i); n_ = nn(i); l_ = ll(i);
    chk("done_count", n_done, 1);
    chk("busy_at_done", busy_at_done, 0);
    chk("load_req_count", n_lrise, k_);
    chk("bm_start_count", n_bms, k_);
    m = imin(pq.size(), k_);
    for (int p = 0; p < m; p++) begin chk("poly_seq", pq[p], p); if (!last_ok) break; end
    chk("fetch_len", abq.size(), k_ * n_);
    chk("bm_load_len", blq.size(), k_ * n_);
    m = imin(abq.size(), blq.size());
    for (int j = 0; j < m; j++) begin
      chk("fetch_addr", aba[j], j % n_);       if (!last_ok) break;
      chk("bm_load_lag", blq[j] - abq[j], l_); if (!last_ok) break;
    end
    chk("acc_rd_with_c", n_rd_cre, (k_ - 1) * n_);
    chk("acc_rd_first", n_rd_only, n_);
    chk("redc_rd", n_cre_only, redc ? n_ : 0);
    for (int p = 0; p < k_; p++)
      for (int a = 0; a < n_; a++) begin ea.push_back(a); ef.push_back(p == 0); eb.push_back(0); end
    if (redc)
      for (int a = 0; a < n_; a++) begin ea.push_back(a); ef.push_back(0); eb.push_back(1); end
    chk("rd_len", rdq.size(), ea.size());
    chk("wr_len", wra.size(), ea.size());
    m = imin(imin(rdq.size(), wra.size()), ea.size());
    for (int j = 0; j < m; j++) begin
      chk("rd_addr", rda[j], ea[j]);            if (!last_ok) break;
      chk("c_waddr", wra[j], ea[j]);            if (!last_ok) break;
      chk("acc_first", wrf[j], ef[j]);          if (!last_ok) break;
      chk("barr_redc", wrb[j], eb[j]);          if (!last_ok) break;
      chk("we_lag", wrcq[j] - rdq[j], l_);      if (!last_ok) break;
    end
  endtask

  initial begin
    int t, ii, rr, ld_r, bm_r;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin st[i] = 1'b0; rdc[i] = 1'b0; clr[i] = 1'b0; end
    tick(3);
    chk("reset_outs_0", outs(0), 0);
    chk("reset_outs_1", outs(1), 0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_outs_0", outs(0), 0);
    chk("idle_outs_1", outs(1), 0);

    // Directed runs on both configurations, with and without the Barrett pass.
    run_begin(0, 1'b0, 2, 5); run_wait(500);  run_check(0, 1'b0);
    run_begin(0, 1'b1, 2, 5); run_wait(500);  run_check(0, 1'b1);
    run_begin(1, 1'b0, 2, 5); run_wait(5000); run_check(1, 1'b0);
    run_begin(1, 1'b1, 0, 1); run_wait(5000); run_check(1, 1'b1);

    // bm_done high from reset: only a fresh rising edge may start the accumulate.
    rst_n = 1'b0; sel = 0; auto_bm = 1'b0; man_bmd = 1'b1;
    tick(2); rst_n = 1'b1; tick(2);
    run_begin(0, 1'b0, 2, 5);
    t = 0;
    while (n_bms == 0 && t < 50) begin tick(1); t++; end
    chk("stale_kick_seen", n_bms, 1);
    tick(6);
    chk("stale_high_no_acc", n_rd_only + n_rd_cre, 0);
    man_bmd = 1'b0; tick(3);
    chk("stale_low_no_acc", n_rd_only + n_rd_cre, 0);
    man_bmd = 1'b1; tick(3);
    chk("acc_after_edge", n_rd_only > 0, 1);
    auto_bm = 1'b1;
    run_wait(500); run_check(0, 1'b0);

    // clr in the middle of the first accumulate sweep.
    run_begin(0, 1'b0, 1, 3);
    t = 0;
    while (!(bm_rd[0] === 1'b1 && addr[0] == 7'd2) && t < 200) begin tick(1); t++; end
    chk("clr_point_reached", bm_rd[0] && addr[0] == 7'd2, 1);
    chk("we_before_clr", wra.size(), 2);
    clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
    chk("clr_outs", outs(0), 0);
    tick(8);
    chk("clr_no_more_we", wra.size(), 2);
    chk("clr_no_done", n_done, 0);
    st[0] = 1'b1; clr[0] = 1'b1; tick(1); st[0] = 1'b0; clr[0] = 1'b0;
    chk("clr_beats_start", busy[0], 0);
    tick(2);
    chk("clr_beats_start_idle", outs(0), 0);

    // Randomised runs.
    for (int r = 0; r < 4; r++) begin
      ii = $urandom_range(0, 1); rr = $urandom_range(0, 1);
      ld_r = $urandom_range(0, 4); bm_r = $urandom_range(1, 8);
      run_begin(ii, rr[0], ld_r, bm_r); run_wait(6000); run_check(ii, rr[0]);
    end

    // Restart ignored while busy, then asynchronous reset during the second FETCH.
    run_begin(1, 1'b1, 1, 3);
    t = 0;
    while (!(ram_ab_re[1] === 1'b1 && addr[1] == 7'd5) && t < 100) begin tick(1); t++; end
    chk("fetch_point_reached", ram_ab_re[1] && addr[1] == 7'd5, 1);
    st[1] = 1'b1; tick(1); st[1] = 1'b0;
    chk("restart_ignored_addr", addr[1], 6);
    chk("restart_ignored_poly", poly_idx[1], 0);
    chk("restart_ignored_busy", busy[1], 1);
    t = 0;
    while (!(ram_ab_re[1] === 1'b1 && poly_idx[1] == 2'd1) && t < 1000) begin tick(1); t++; end
    chk("second_fetch_reached", ram_ab_re[1] && poly_idx[1] == 2'd1, 1);
    rst_n = 1'b0; #1;
    chk("async_reset_outs", outs(1), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("reset_no_done", n_done, 0);
    chk("post_reset_outs", outs(1), 0);
    run_begin(1, 1'b0, 2, 5); run_wait(5000); run_check(1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/polyvec_basemul_acc_seq.md
Name: polyvec_basemul_acc_seq

Overview:
- Parametrised sequencer for the polyvec pointwise multiply-accumulate.
- Drives a basemul core and its coefficient RAMs (A/B operands, C accumulator) across KYBER_K polynomial pairs.
- Optionally finishes with a Barrett reduction pass over RAM C.
- Owns its own address counter, poly index and RAM-latency pipeline, and exposes a start/busy/done handshake to the top-level controller.

Parameters:
KYBER_K, 3, number of polynomial pairs accumulated per run; legal 2..4.
NPAIRS, 128, coefficient pairs per polynomial; addresses 0..NPAIRS-1.
AW, 7, address width; must satisfy 2^AW >= NPAIRS.
RD_LAT, 1, RAM read latency in cycles; legal 1..3.

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle run request; honoured only in IDLE
redc_en  in  1  mode: 1 = Barrett pass after accumulation; sampled when start accepted
clr  in  1  synchronous abort; returns to IDLE next cycle
load_done  in  1  operand loader has filled RAM A/B for current poly
bm_done  in  1  basemul core done level; rising edge consumed
load_req  out  1  level; request operand load for poly_idx
poly_idx  out  2  current polynomial index 0..KYBER_K-1
addr  out  AW  read address to RAM A/B/C
ram_ab_re  out  1  RAM A/B read enable
bm_load  out  1  operand valid into core (ram_ab_re delayed RD_LAT)
bm_start  out  1  one-cycle core kick
bm_rd  out  1  core result read strobe
ram_c_re  out  1  RAM C read enable
ram_c_we  out  1  RAM C write enable
c_waddr  out  AW  RAM C write address (addr delayed RD_LAT)
acc_first  out  1  1 = write product directly, 0 = add to C; aligned with ram_c_we
barr_redc  out  1  datapath selects Barrett path; aligned with ram_c_we
busy  out  1  high from start acceptance until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset_n low, async): state IDLE; every output 0; internal counter, poly_idx and delay lines cleared.
- IDLE:
  - start=1 → WAIT_LOAD.
  - Sets busy=1, poly_idx=0; latches redc_en.
  - start while busy is ignored.
- WAIT_LOAD: load_req=1 until load_done=1 → FETCH. load_req drops in the same cycle the transition occurs.
- FETCH:
  - addr sweeps 0..NPAIRS-1, one per cycle, with ram_ab_re=1.
  - bm_load mirrors ram_ab_re delayed RD_LAT.
  - Lasts NPAIRS+RD_LAT cycles (drain) → KICK.
- KICK: bm_start=1 for exactly one cycle → WAIT_BM.
- WAIT_BM:
  - bm_done is registered each cycle; leaves only on a rising edge (bm_done=1, previous 0).
  - A stale high level left from the prior run is never accepted.
  - Edge seen → ACC.
- ACC:
  - addr sweeps 0..NPAIRS-1 with bm_rd=1; ram_c_re=1 only when poly_idx>0.
  - ram_c_we, c_waddr and acc_first=(poly_idx==0) appear RD_LAT cycles after the matching read.
  - Lasts NPAIRS+RD_LAT cycles.
  - Exit: poly_idx==KYBER_K-1 → REDC if latched redc_en, else FIN. Otherwise poly_idx+1 → WAIT_LOAD.
- REDC:
  - addr sweeps 0..NPAIRS-1 with ram_c_re=1.
  - ram_c_we and barr_redc=1 appear RD_LAT cycles later; acc_first=0.
  - Lasts NPAIRS+RD_LAT cycles → FIN.
- FIN: done=1 for one cycle, busy→0 in the same cycle → IDLE.
- Counter wrap: the address counter never exceeds NPAIRS-1. It resets to 0 at each sweep entry and holds during drain.
- clr: highest priority after reset.
  - Next cycle: IDLE, all strobes 0, in-flight delayed writes discarded (no ram_c_we), busy=0, done not pulsed.
- Simultaneous clr and start in IDLE: clr wins.
- reset_n asserted mid-run: immediate return to reset values; no partial done.
- bm_done rising in any state other than WAIT_BM is ignored. The edge register still updates.

Test Plan:
- KYBER_K=2, NPAIRS=4, RD_LAT=1, redc_en=0, load_done 2 cycles after load_req, bm_done rises 5 cycles after bm_start → two load_req/bm_start cycles. First ACC: 4 ram_c_we with acc_first=1, c_waddr 0,1,2,3. Second ACC: ram_c_re=1, acc_first=0. Then done one cycle, busy low.
- Same config, redc_en=1 → after the second ACC, 4 ram_c_we with barr_redc=1, c_waddr 0..3, then done.
- KYBER_K=4, NPAIRS=128, RD_LAT=2 → poly_idx steps 0,1,2,3. Each sweep has exactly 128 ram_c_we; each ram_c_we lags its read by 2 cycles.
- bm_done held high from reset, dropped, then re-raised → WAIT_BM exits only on the re-raise; no early ACC.
- clr asserted mid-ACC at addr=2 → next cycle IDLE, no further ram_c_we (including the delayed one), busy=0, done never pulses.
- start pulsed again mid-run; reset_n pulsed low during FETCH → second start ignored; after reset all outputs 0 and a fresh start completes normally.
